// File: rtl/sys2dfu_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sys2dfu_wb_pkg                                               |
// | Description : Shared types and default sizes for the array write-back path |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sys2dfu_wb_pkg;

    localparam int c_ES_DEF         = 16;
    localparam int c_BANKS_DEF      = 4;
    localparam int c_SEL_W_DEF      = $clog2(c_BANKS_DEF);
    localparam int c_ADDR_W_DEF     = 8;
    localparam int c_FIFO_DEPTH_DEF = 4;
    localparam int c_FIFO_PTR_W     = $clog2(c_FIFO_DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/sys2dfu_wb_demux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sys2dfu_wb_demux_if                                          |
// | Description : Controller, array and SRAM-side signals of the write-back    |
// |               demux; slave is the demux view, master the environment view  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sys2dfu_wb_demux_if
    import sys2dfu_wb_pkg::*;
#(
    parameter int Es               = c_ES_DEF,
    parameter int no_of_sram_banks = c_BANKS_DEF,
    parameter int no_of_sel_ln     = c_SEL_W_DEF,
    parameter int ADDR_W           = c_ADDR_W_DEF
) ();

    logic                    start_wb;
    logic [ADDR_W-1:0]       wb_len;
    logic [ADDR_W-1:0]       wb_base_addr;
    logic [no_of_sel_ln-1:0] wb_demux_sel     [0:no_of_sram_banks-1];
    logic [Es-1:0]           sys2dfu_data_in  [0:no_of_sram_banks-1];
    logic                    sys2dfu_data_vld [0:no_of_sram_banks-1];
    logic                    sram_wr_rdy      [0:no_of_sram_banks-1];
    logic                    dfu2sram_wr_en   [0:no_of_sram_banks-1];
    logic [ADDR_W-1:0]       dfu2sram_wr_addr [0:no_of_sram_banks-1];
    logic [Es-1:0]           dfu2sram_wr_data [0:no_of_sram_banks-1];
    logic                    sys2dfu_stall    [0:no_of_sram_banks-1];
    logic                    ack_wb_start;
    logic                    wb_busy;
    logic                    wb_done;
    logic                    wb_err;

    modport slave (
        input  start_wb, wb_len, wb_base_addr, wb_demux_sel,
        input  sys2dfu_data_in, sys2dfu_data_vld, sram_wr_rdy,
        output dfu2sram_wr_en, dfu2sram_wr_addr, dfu2sram_wr_data,
        output sys2dfu_stall, ack_wb_start, wb_busy, wb_done, wb_err
    );

    modport master (
        output start_wb, wb_len, wb_base_addr, wb_demux_sel,
        output sys2dfu_data_in, sys2dfu_data_vld, sram_wr_rdy,
        input  dfu2sram_wr_en, dfu2sram_wr_addr, dfu2sram_wr_data,
        input  sys2dfu_stall, ack_wb_start, wb_busy, wb_done, wb_err
    );

endinterface
`default_nettype wire

// File: rtl/wb_lane_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_lane_fifo                                                 |
// | Description : Per-lane synchronous FIFO with a combinational head output   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_lane_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sys2dfu_wb_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sys2dfu_wb_demux                                             |
// | Description : Steers buffered array lanes to SRAM banks with per-lane      |
// |               addressing. Optional macro WB_CONFLICT_CHECK_EN rejects a    |
// |               non-permutation bank select at start.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sys2dfu_wb_demux
    import sys2dfu_wb_pkg::*;
#(
    parameter int Es               = c_ES_DEF,
    parameter int no_of_sram_banks = c_BANKS_DEF,
    parameter int no_of_sel_ln     = c_SEL_W_DEF,
    parameter int ADDR_W           = c_ADDR_W_DEF,
    parameter int FIFO_DEPTH       = c_FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    sys2dfu_wb_demux_if.slave       bus
);

    localparam int c_N     = no_of_sram_banks;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_state_t               r_state;
    logic [no_of_sel_ln-1:0] r_sel      [0:c_N-1];
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W-1:0]       r_len;
    logic [ADDR_W-1:0]       r_accepted [0:c_N-1];
    logic [ADDR_W-1:0]       r_written  [0:c_N-1];
    logic                    r_wr_en    [0:c_N-1];
    logic [ADDR_W-1:0]       r_wr_addr  [0:c_N-1];
    logic [Es-1:0]           r_wr_data  [0:c_N-1];
    logic                    r_stall    [0:c_N-1];
    logic                    r_ack;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;

    logic [Es-1:0]           w_head     [0:c_N-1];
    logic                    w_full     [0:c_N-1];
    logic                    w_empty    [0:c_N-1];
    logic [c_CNT_W-1:0]      w_count    [0:c_N-1];
    logic [c_CNT_W-1:0]      w_nxt_cnt  [0:c_N-1];
    logic                    w_want     [0:c_N-1];
    logic                    w_push     [0:c_N-1];
    logic                    w_pop      [0:c_N-1];
    logic                    w_ovf      [0:c_N-1];
    logic                    w_all_written;
    logic                    w_conflict;

    generate
        for (genvar g = 0; g < c_N; g++) begin : g_lane
            wb_lane_fifo #(
                .WIDTH (Es),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push[g]),
                .pop   (w_pop[g]),
                .din   (bus.sys2dfu_data_in[g]),
                .dout  (w_head[g]),
                .full  (w_full[g]),
                .empty (w_empty[g]),
                .count (w_count[g])
            );
        end
    endgenerate

    // Lowest-index lane holding data wins a shared bank; a pop on a full
    // FIFO frees the slot for a same-cycle push.
    always_comb begin
        for (int i = 0; i < c_N; i++) begin
            w_pop[i] = (r_state == COLLECT) && !w_empty[i] && bus.sram_wr_rdy[r_sel[i]];
            for (int j = 0; j < c_N; j++) begin
                if (j < i && !w_empty[j] && (r_sel[j] == r_sel[i])) w_pop[i] = 1'b0;
            end
            w_want[i]    = (r_state == COLLECT) && bus.sys2dfu_data_vld[i] && (r_accepted[i] < r_len);
            w_push[i]    = w_want[i] && (!w_full[i] || w_pop[i]);
            w_ovf[i]     = w_want[i] && w_full[i] && !w_pop[i];
            w_nxt_cnt[i] = w_count[i] + c_CNT_W'(w_push[i]) - c_CNT_W'(w_pop[i]);
        end
    end

    always_comb begin
        w_all_written = 1'b1;
        for (int i = 0; i < c_N; i++) begin
            if (r_written[i] != r_len) w_all_written = 1'b0;
        end
    end

`ifdef WB_CONFLICT_CHECK_EN
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            for (int j = 0; j < c_N; j++) begin
                if (j > i && (bus.wb_demux_sel[i] == bus.wb_demux_sel[j])) w_conflict = 1'b1;
            end
        end
    end
`else
    assign w_conflict = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < c_N; i++) begin
                r_sel[i]      <= '0;
                r_accepted[i] <= '0;
                r_written[i]  <= '0;
                r_wr_en[i]    <= 1'b0;
                r_wr_addr[i]  <= '0;
                r_wr_data[i]  <= '0;
                r_stall[i]    <= 1'b0;
            end
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            for (int i = 0; i < c_N; i++) begin
                r_wr_en[i] <= 1'b0;
            end
            for (int i = 0; i < c_N; i++) begin
                r_stall[i] <= (w_nxt_cnt[i] >= c_CNT_W'(FIFO_DEPTH - 1));
                if (w_push[i]) r_accepted[i] <= r_accepted[i] + 1'b1;
                if (w_ovf[i])  r_err <= 1'b1;
                if (w_pop[i]) begin
                    r_written[i]        <= r_written[i] + 1'b1;
                    r_wr_en[r_sel[i]]   <= 1'b1;
                    r_wr_addr[r_sel[i]] <= r_base + r_written[i];
                    r_wr_data[r_sel[i]] <= w_head[i];
                end
            end

            case (r_state)
                IDLE: begin
                    if (bus.start_wb) begin
                        r_base <= bus.wb_base_addr;
                        r_len  <= bus.wb_len;
                        r_ack  <= 1'b1;
                        r_err  <= 1'b0;
                        for (int i = 0; i < c_N; i++) begin
                            r_sel[i]      <= bus.wb_demux_sel[i];
                            r_accepted[i] <= '0;
                            r_written[i]  <= '0;
                        end
                        if (w_conflict) begin
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else if (bus.wb_len == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= COLLECT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (w_all_written) r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dfu2sram_wr_en   = r_wr_en;
    assign bus.dfu2sram_wr_addr = r_wr_addr;
    assign bus.dfu2sram_wr_data = r_wr_data;
    assign bus.sys2dfu_stall    = r_stall;
    assign bus.ack_wb_start     = r_ack;
    assign bus.wb_busy          = r_busy;
    assign bus.wb_done          = r_done;
    assign bus.wb_err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sys2dfu_wb_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sys2dfu_wb_demux                                          |
// | Description : Directed self-checking bench for the write-back demux        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sys2dfu_wb_demux;

    localparam int c_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   tid = 0;

    logic [23:0] got_q [c_N][$];
    logic [23:0] exp_q [c_N][$];

    sys2dfu_wb_demux_if bus ();

    sys2dfu_wb_demux dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Write and done log, sampled mid-cycle.
    always @(negedge clk) begin
        for (int b = 0; b < c_N; b++) begin
            if (bus.dfu2sram_wr_en[b]) got_q[b].push_back({bus.dfu2sram_wr_addr[b], bus.dfu2sram_wr_data[b]});
        end
        if (bus.wb_done) n_done++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat(input int lane, input int row);
        return 16'((tid << 12) | (lane << 8) | row);
    endfunction

    function automatic logic [31:0] outs_vec();
        logic [31:0] v;
        v = {28'd0, bus.wb_err, bus.wb_done, bus.wb_busy, bus.ack_wb_start};
        for (int i = 0; i < c_N; i++) begin
            v[4+i] = bus.sys2dfu_stall[i];
            v[8+i] = bus.dfu2sram_wr_en[i];
        end
        return v;
    endfunction

    function automatic logic [31:0] addr_data_or();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < c_N; i++) v = v | {8'd0, bus.dfu2sram_wr_addr[i], bus.dfu2sram_wr_data[i]};
        return v;
    endfunction

    task automatic set_sel(input int s0, input int s1, input int s2, input int s3);
        bus.wb_demux_sel[0] = 2'(s0);
        bus.wb_demux_sel[1] = 2'(s1);
        bus.wb_demux_sel[2] = 2'(s2);
        bus.wb_demux_sel[3] = 2'(s3);
    endtask

    task automatic set_rdy(input logic [3:0] m);
        for (int i = 0; i < c_N; i++) bus.sram_wr_rdy[i] = m[i];
    endtask

    task automatic start(input string tag, input logic [7:0] base, input logic [7:0] len);
        bus.wb_base_addr = base;
        bus.wb_len       = len;
        bus.start_wb     = 1'b1;
        tick();
        bus.start_wb     = 1'b0;
        check_val({tag, "_ack"}, 32'(bus.ack_wb_start), 32'd1);
    endtask

    task automatic exp_lane(input int bank, input int lane, input logic [7:0] base, input int rows);
        for (int r = 0; r < rows; r++) exp_q[bank].push_back({8'(base + 8'(r)), pat(lane, r)});
    endtask

    // Drives rows on every lane; a lane only holds back while stalled if asked.
    task automatic feed(input string tag, input int rows, input bit obey_stall, input int budget);
        int row [c_N];
        int cyc;
        bit busy_lanes;
        for (int i = 0; i < c_N; i++) row[i] = 0;
        cyc = 0;
        busy_lanes = 1'b1;
        while (busy_lanes && cyc < budget) begin
            for (int i = 0; i < c_N; i++) begin
                bus.sys2dfu_data_vld[i] = 1'b0;
                if (row[i] < rows && !(obey_stall && bus.sys2dfu_stall[i])) begin
                    bus.sys2dfu_data_vld[i] = 1'b1;
                    bus.sys2dfu_data_in[i]  = pat(i, row[i]);
                    row[i]++;
                end
            end
            tick();
            cyc++;
            busy_lanes = 1'b0;
            for (int i = 0; i < c_N; i++) if (row[i] < rows) busy_lanes = 1'b1;
        end
        for (int i = 0; i < c_N; i++) bus.sys2dfu_data_vld[i] = 1'b0;
        if (busy_lanes) check_val({tag, "_feed_timeout"}, 32'(cyc), 32'(budget + 1));
    endtask

    task automatic wait_done(input string tag, input int prev, input int budget);
        int cyc;
        cyc = 0;
        while (n_done == prev && cyc < budget) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        check_val({tag, "_done_pulses"}, 32'(n_done - prev), 32'd1);
    endtask

    task automatic compare(input string tag);
        int n;
        for (int b = 0; b < c_N; b++) begin
            check_val($sformatf("%s_b%0d_count", tag, b), 32'(got_q[b].size()), 32'(exp_q[b].size()));
            n = (got_q[b].size() < exp_q[b].size()) ? got_q[b].size() : exp_q[b].size();
            for (int k = 0; k < n; k++)
                check_val($sformatf("%s_b%0d_w%0d", tag, b, k), 32'(got_q[b][k]), 32'(exp_q[b][k]));
            got_q[b].delete();
            exp_q[b].delete();
        end
    endtask

    initial begin
        int prev;
        bus.start_wb     = 1'b0;
        bus.wb_len       = '0;
        bus.wb_base_addr = '0;
        for (int i = 0; i < c_N; i++) begin
            bus.wb_demux_sel[i]     = '0;
            bus.sys2dfu_data_in[i]  = '0;
            bus.sys2dfu_data_vld[i] = 1'b0;
            bus.sram_wr_rdy[i]      = 1'b0;
        end

        repeat (3) tick();
        check_val("rst_outs", outs_vec(), 32'd0);
        check_val("rst_addr_data", addr_data_or(), 32'd0);
        rst = 1'b1;
        tick();

        // Identity map.
        tid = 1;
        set_sel(0, 1, 2, 3);
        set_rdy(4'hF);
        prev = n_done;
        start("t1", 8'h10, 8'd3);
        check_val("t1_busy", 32'(bus.wb_busy), 32'd1);
        feed("t1", 3, 1'b1, 40);
        wait_done("t1", prev, 40);
        check_val("t1_err", 32'(bus.wb_err), 32'd0);
        check_val("t1_busy_end", 32'(bus.wb_busy), 32'd0);
        for (int i = 0; i < c_N; i++) exp_lane(i, i, 8'h10, 3);
        compare("t1");

        // Permuted map, bank 3 held off for six cycles.
        tid = 2;
        set_sel(3, 2, 1, 0);
        set_rdy(4'h7);
        prev = n_done;
        start("t2", 8'h20, 8'd4);
        fork
            feed("t2", 4, 1'b1, 60);
            begin
                tick();
                tick();
                check_val("t2_stall0_occ2", 32'(bus.sys2dfu_stall[0]), 32'd0);
                tick();
                check_val("t2_stall0_occ3", 32'(bus.sys2dfu_stall[0]), 32'd1);
                tick();
                tick();
                tick();
                check_val("t2_b3_idle", 32'(got_q[3].size()), 32'd0);
                bus.sram_wr_rdy[3] = 1'b1;
            end
        join
        wait_done("t2", prev, 60);
        check_val("t2_stall_end", outs_vec() & 32'hF0, 32'd0);
        exp_lane(3, 0, 8'h20, 4);
        exp_lane(2, 1, 8'h20, 4);
        exp_lane(1, 2, 8'h20, 4);
        exp_lane(0, 3, 8'h20, 4);
        compare("t2");

        // Address wrap.
        tid = 3;
        set_sel(0, 1, 2, 3);
        prev = n_done;
        start("t3", 8'hFE, 8'd3);
        feed("t3", 3, 1'b1, 40);
        wait_done("t3", prev, 40);
        for (int i = 0; i < c_N; i++) exp_lane(i, i, 8'hFE, 3);
        compare("t3");

        // Zero length: done the cycle after ack, no writes.
        tid = 4;
        start("t4", 8'h00, 8'd0);
        check_val("t4_busy", 32'(bus.wb_busy), 32'd0);
        check_val("t4_done_early", 32'(bus.wb_done), 32'd0);
        tick();
        check_val("t4_done", 32'(bus.wb_done), 32'd1);
        check_val("t4_ack_off", 32'(bus.ack_wb_start), 32'd0);
        tick();
        check_val("t4_done_off", 32'(bus.wb_done), 32'd0);
        compare("t4");

        // Overflow: lane 0 pushes past a full FIFO with banks blocked.
        tid = 5;
        set_rdy(4'h0);
        start("t5", 8'h00, 8'd10);
        bus.sys2dfu_data_vld[0] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus.sys2dfu_data_in[0] = pat(0, r);
            tick();
        end
        check_val("t5_err_4push", 32'(bus.wb_err), 32'd0);
        bus.sys2dfu_data_in[0] = pat(0, 4);
        tick();
        bus.sys2dfu_data_vld[0] = 1'b0;
        check_val("t5_err_5push", 32'(bus.wb_err), 32'd1);
        rst = 1'b0;
        tick();
        check_val("t5_rst_outs", outs_vec(), 32'd0);
        rst = 1'b1;
        set_rdy(4'hF);
        repeat (8) tick();
        compare("t5");

        // Reset with two entries queued aborts the transfer.
        tid = 6;
        set_rdy(4'h0);
        start("t6", 8'h30, 8'd10);
        bus.sys2dfu_data_vld[0] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            bus.sys2dfu_data_in[0] = pat(0, r);
            tick();
        end
        bus.sys2dfu_data_vld[0] = 1'b0;
        check_val("t6_busy_pre", 32'(bus.wb_busy), 32'd1);
        rst = 1'b0;
        tick();
        check_val("t6_rst_outs", outs_vec(), 32'd0);
        rst = 1'b1;
        set_rdy(4'hF);
        repeat (8) tick();
        compare("t6");

        // Valid beyond len is discarded.
        tid = 7;
        prev = n_done;
        start("t7", 8'h50, 8'd2);
        feed("t7", 4, 1'b0, 10);
        wait_done("t7", prev, 30);
        check_val("t7_err", 32'(bus.wb_err), 32'd0);
        for (int i = 0; i < c_N; i++) exp_lane(i, i, 8'h50, 2);
        compare("t7");

        // Two lanes mapped to bank 1.
        tid = 8;
        set_sel(1, 1, 2, 3);
        prev = n_done;
        start("t8", 8'h40, 8'd3);
`ifdef WB_CONFLICT_CHECK_EN
        check_val("t8_err_early", 32'(bus.wb_err), 32'd1);
        wait_done("t8", prev, 10);
        check_val("t8_err", 32'(bus.wb_err), 32'd1);
`else
        feed("t8", 3, 1'b1, 40);
        wait_done("t8", prev, 50);
        check_val("t8_err", 32'(bus.wb_err), 32'd0);
        exp_lane(1, 0, 8'h40, 3);
        exp_lane(1, 1, 8'h40, 3);
        exp_lane(2, 2, 8'h40, 3);
        exp_lane(3, 3, 8'h40, 3);
`endif
        compare("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
